icmd_mem_arbiter: RTL and testbench

- Shares the single DDR2 Avalon-MM master port between three requesters:
  - Reader A: IC burst read, fetching raw image data into FF1.
  - Writer W: IC single write, draining FF2.
  - Reader B: MD burst read, fetching grayscale lines for motion detection.
- Round-robin scheduling; a read grant is locked for a whole burst and a write grant for a bounded run.
- Sits between the IC/MD master interfaces and the DDR2 controller, inside icmd_controller.

---
 rtl/icmd_mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_icmd_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icmd_mem_arbiter.sv
// rtl/icmd_mem_arbiter.sv - round-robin DDR2 Avalon-MM port arbiter for IC reader, IC writer and MD reader
module icmd_mem_arbiter #(
   parameter int BURST_W    = 8,
   parameter int MAX_WR_RUN = 16
) (
   input  logic               clk,
   input  logic               reset,
   // Reader A (IC burst read into FF1)
   input  logic               A_read,
   input  logic [31:0]        A_address,
   input  logic [BURST_W-1:0] A_burstcount,
   output logic               A_waitrequest,
   output logic               A_readdatavalid,
   output logic [31:0]        A_readdata,
   // Writer W (IC single writes draining FF2)
   input  logic               W_write,
   input  logic [31:0]        W_address,
   input  logic [31:0]        W_writedata,
   output logic               W_waitrequest,
   // Reader B (MD grayscale burst read)
   input  logic               B_read,
   input  logic [31:0]        B_address,
   input  logic [BURST_W-1:0] B_burstcount,
   output logic               B_waitrequest,
   output logic               B_readdatavalid,
   output logic [31:0]        B_readdata,
   // Downstream DDR2 controller port
   output logic               M_read,
   output logic               M_write,
   output logic [31:0]        M_address,
   output logic [BURST_W-1:0] M_burstcount,
   output logic [31:0]        M_writedata,
   input  logic               M_waitrequest,
   input  logic               M_readdatavalid,
   input  logic [31:0]        M_readdata,
   // Status
   output logic [2:0]         grant,
   output logic               protocol_error
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      A_CMD  = 3'd1,
      A_DATA = 3'd2,
      W_RUN  = 3'd3,
      B_CMD  = 3'd4,
      B_DATA = 3'd5
   } state_t;

   // Rotating priority pointer: the requester checked first in IDLE.
   localparam logic [1:0] P_A = 2'd0;
   localparam logic [1:0] P_W = 2'd1;
   localparam logic [1:0] P_B = 2'd2;

   // Run count value whose accepted write closes the W grant.
   localparam logic [7:0] RUN_LAST = 8'(MAX_WR_RUN - 1);
   localparam logic [BURST_W-1:0] ONE_BEAT = BURST_W'(1);

   state_t             state, state_n;
   logic [1:0]         ptr, ptr_n;
   logic [BURST_W-1:0] beats, beats_n;
   logic [7:0]         run_cnt, run_n;
   logic               err_n;

   // Read data is shared; only the owner's readdatavalid qualifies it.
   assign A_readdata = M_readdata;
   assign B_readdata = M_readdata;

   // State, pointer, counters and sticky error register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         ptr            <= P_A;
         beats          <= '0;
         run_cnt        <= '0;
         protocol_error <= 1'b0;
      end else begin
         state          <= state_n;
         ptr            <= ptr_n;
         beats          <= beats_n;
         run_cnt        <= run_n;
         protocol_error <= err_n;
      end
   end

   // Next-state logic, command mux and per-requester handshakes.
   always_comb begin
      state_n         = state;
      ptr_n           = ptr;
      beats_n         = beats;
      run_n           = run_cnt;
      err_n           = protocol_error;
      M_read          = 1'b0;
      M_write         = 1'b0;
      M_address       = '0;
      M_burstcount    = '0;
      M_writedata     = '0;
      A_waitrequest   = 1'b1;
      W_waitrequest   = 1'b1;
      B_waitrequest   = 1'b1;
      A_readdatavalid = 1'b0;
      B_readdatavalid = 1'b0;
      grant           = 3'b000;

      // Beats outside a data phase belong to nobody and are dropped.
      if (M_readdatavalid && state != A_DATA && state != B_DATA) begin
         err_n = 1'b1;
      end

      case (state)
         IDLE: begin
            case (ptr)
               P_W: begin
                  if (W_write)     state_n = W_RUN;
                  else if (B_read) state_n = B_CMD;
                  else if (A_read) state_n = A_CMD;
               end
               P_B: begin
                  if (B_read)       state_n = B_CMD;
                  else if (A_read)  state_n = A_CMD;
                  else if (W_write) state_n = W_RUN;
               end
               default: begin
                  if (A_read)       state_n = A_CMD;
                  else if (W_write) state_n = W_RUN;
                  else if (B_read)  state_n = B_CMD;
               end
            endcase
         end

         A_CMD: begin
            grant         = 3'b001;
            M_read        = A_read;
            M_address     = A_address;
            M_burstcount  = A_burstcount;
            A_waitrequest = M_waitrequest;
            if (!A_read) begin
               // Requester withdrew a granted command: give up the slot.
               state_n = IDLE;
               ptr_n   = P_W;
               err_n   = 1'b1;
            end else if (!M_waitrequest) begin
               state_n = A_DATA;
               beats_n = (A_burstcount == '0) ? ONE_BEAT : A_burstcount;
            end
         end

         A_DATA: begin
            grant           = 3'b001;
            A_readdatavalid = M_readdatavalid;
            if (M_readdatavalid) begin
               beats_n = beats - ONE_BEAT;
               if (beats == ONE_BEAT) begin
                  state_n = IDLE;
                  ptr_n   = P_W;
               end
            end
         end

         W_RUN: begin
            grant         = 3'b010;
            M_write       = W_write;
            M_address     = W_address;
            M_burstcount  = ONE_BEAT;
            M_writedata   = W_writedata;
            W_waitrequest = M_waitrequest;
            if (!W_write) begin
               state_n = IDLE;
               ptr_n   = P_B;
               run_n   = '0;
            end else if (!M_waitrequest) begin
               if (run_cnt == RUN_LAST) begin
                  state_n = IDLE;
                  ptr_n   = P_B;
                  run_n   = '0;
               end else begin
                  run_n = run_cnt + 8'd1;
               end
            end
         end

         B_CMD: begin
            grant         = 3'b100;
            M_read        = B_read;
            M_address     = B_address;
            M_burstcount  = B_burstcount;
            B_waitrequest = M_waitrequest;
            if (!B_read) begin
               state_n = IDLE;
               ptr_n   = P_A;
               err_n   = 1'b1;
            end else if (!M_waitrequest) begin
               state_n = B_DATA;
               beats_n = (B_burstcount == '0) ? ONE_BEAT : B_burstcount;
            end
         end

         B_DATA: begin
            grant           = 3'b100;
            B_readdatavalid = M_readdatavalid;
            if (M_readdatavalid) begin
               beats_n = beats - ONE_BEAT;
               if (beats == ONE_BEAT) begin
                  state_n = IDLE;
                  ptr_n   = P_A;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_icmd_mem_arbiter.sv
// tb/tb_icmd_mem_arbiter.sv - directed self-checking bench for icmd_mem_arbiter
module tb_icmd_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        A_read, A_waitrequest, A_readdatavalid;
   logic [31:0] A_address, A_readdata;
   logic [7:0]  A_burstcount;
   logic        W_write, W_waitrequest;
   logic [31:0] W_address, W_writedata;
   logic        B_read, B_waitrequest, B_readdatavalid;
   logic [31:0] B_address, B_readdata;
   logic [7:0]  B_burstcount;
   logic        M_read, M_write, M_waitrequest, M_readdatavalid;
   logic [31:0] M_address, M_writedata, M_readdata;
   logic [7:0]  M_burstcount;
   logic [2:0]  grant;
   logic        protocol_error;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0] seq [6];
   logic [2:0] exp_seq [6];
   int         wcnt [6];

   icmd_mem_arbiter #(.BURST_W(8), .MAX_WR_RUN(16)) dut (
      .clk(clk), .reset(reset),
      .A_read(A_read), .A_address(A_address), .A_burstcount(A_burstcount),
      .A_waitrequest(A_waitrequest), .A_readdatavalid(A_readdatavalid), .A_readdata(A_readdata),
      .W_write(W_write), .W_address(W_address), .W_writedata(W_writedata),
      .W_waitrequest(W_waitrequest),
      .B_read(B_read), .B_address(B_address), .B_burstcount(B_burstcount),
      .B_waitrequest(B_waitrequest), .B_readdatavalid(B_readdatavalid), .B_readdata(B_readdata),
      .M_read(M_read), .M_write(M_write), .M_address(M_address), .M_burstcount(M_burstcount),
      .M_writedata(M_writedata), .M_waitrequest(M_waitrequest),
      .M_readdatavalid(M_readdatavalid), .M_readdata(M_readdata),
      .grant(grant), .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] obs;
      repeat (2) @(negedge clk);
      M_readdatavalid = 1'b1;
      #1;
      obs = {M_read, M_write, A_waitrequest, W_waitrequest, B_waitrequest,
             A_readdatavalid, B_readdatavalid, grant, protocol_error};
      n_checks++;
      if (obs !== 11'b00_111_00_000_0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 00111000000", obs);
      end
      M_readdatavalid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if ({grant, protocol_error} !== 4'b000_0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got grant=%b err=%b want 000 0", grant, protocol_error);
      end
   endtask

   task automatic test_single_burst_a();
      int acnt = 0;
      int bcnt = 0;
      @(negedge clk);
      A_read = 1'b1; A_address = 32'h0000_1000; A_burstcount = 8'd8;
      #1;
      n_checks++;
      if (M_read !== 1'b0) begin
         n_fail++;
         $display("FAIL a_latency_early: got M_read=%b want 0", M_read);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({M_read, grant, A_waitrequest, M_address, M_burstcount} !== {1'b1, 3'b001, 1'b0, 32'h0000_1000, 8'd8}) begin
         n_fail++;
         $display("FAIL a_cmd: got rd=%b gnt=%b wr=%b addr=%h bc=%0d want 1 001 0 00001000 8",
                  M_read, grant, A_waitrequest, M_address, M_burstcount);
      end
      @(negedge clk);
      A_read = 1'b0;
      #1;
      n_checks++;
      if ({M_read, grant, A_waitrequest, M_address} !== {1'b0, 3'b001, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL a_data_phase: got rd=%b gnt=%b wr=%b addr=%h want 0 001 1 0",
                  M_read, grant, A_waitrequest, M_address);
      end
      for (int i = 0; i < 8; i++) begin
         M_readdatavalid = 1'b1;
         M_readdata = 32'hA000_0000 + i;
         #1;
         if (A_readdatavalid === 1'b1) acnt++;
         if (B_readdatavalid !== 1'b0) bcnt++;
         if (i == 0) begin
            n_checks++;
            if (A_readdata !== 32'hA000_0000) begin
               n_fail++;
               $display("FAIL a_readdata: got %h want a0000000", A_readdata);
            end
         end
         @(negedge clk);
      end
      M_readdatavalid = 1'b0;
      #1;
      n_checks++;
      if (acnt != 8) begin
         n_fail++;
         $display("FAIL a_beat_count: got %0d want 8", acnt);
      end
      n_checks++;
      if (bcnt != 0) begin
         n_fail++;
         $display("FAIL a_b_rdv_quiet: got %0d B pulses want 0", bcnt);
      end
      n_checks++;
      if (grant !== 3'b000) begin
         n_fail++;
         $display("FAIL a_release: got grant=%b want 000", grant);
      end
   endtask

   task automatic test_round_robin();
      int ng = 0;
      logic [2:0] prev = 3'b000;
      logic done = 1'b0;
      exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
      exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;
      for (int i = 0; i < 6; i++) begin
         wcnt[i] = 0;
         seq[i] = 3'b000;
      end
      do_reset();
      A_burstcount = 8'd4; B_burstcount = 8'd4;
      A_address = 32'h0000_1100; B_address = 32'h0000_2200;
      W_address = 32'h0000_3300; W_writedata = 32'h1234_5678;
      A_read = 1'b1; W_write = 1'b1; B_read = 1'b1;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         #1;
         if (grant !== 3'b000 && prev === 3'b000 && ng < 6) begin
            seq[ng] = grant;
            ng++;
         end
         if (grant === 3'b010 && M_write === 1'b1 && ng > 0) wcnt[ng-1]++;
         M_readdatavalid = (grant === 3'b001 || grant === 3'b100) && M_read === 1'b0;
         prev = grant;
         if (ng == 6 && grant === 3'b000) begin
            A_read = 1'b0; W_write = 1'b0; B_read = 1'b0;
            M_readdatavalid = 1'b0;
            done = 1'b1;
         end
      end
      M_readdatavalid = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL rr_timeout: got %0d grants want 6 then idle", ng);
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (seq[i] !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: got %b want %b", i, seq[i], exp_seq[i]);
         end
      end
      n_checks++;
      if (wcnt[1] != 16 || wcnt[4] != 16) begin
         n_fail++;
         $display("FAIL rr_write_run: got %0d,%0d want 16,16", wcnt[1], wcnt[4]);
      end
      n_checks++;
      if (protocol_error !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_no_error: got %b want 0", protocol_error);
      end
   endtask

   task automatic test_waitrequest();
      @(negedge clk);
      M_waitrequest = 1'b1;
      A_read = 1'b1; A_address = 32'h0000_2000; A_burstcount = 8'd2;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if ({M_read, M_address, A_waitrequest} !== {1'b1, 32'h0000_2000, 1'b1}) begin
            n_fail++;
            $display("FAIL wait_stall_%0d: got rd=%b addr=%h wr=%b want 1 00002000 1",
                     i, M_read, M_address, A_waitrequest);
         end
         @(negedge clk);
      end
      M_waitrequest = 1'b0;
      #1;
      n_checks++;
      if ({M_read, A_waitrequest} !== 2'b10) begin
         n_fail++;
         $display("FAIL wait_accept: got rd=%b wr=%b want 1 0", M_read, A_waitrequest);
      end
      @(negedge clk);
      A_read = 1'b0;
      #1;
      n_checks++;
      if ({grant, M_read} !== 4'b001_0) begin
         n_fail++;
         $display("FAIL wait_data_phase: got gnt=%b rd=%b want 001 0", grant, M_read);
      end
      for (int i = 0; i < 2; i++) begin
         M_readdatavalid = 1'b1;
         @(negedge clk);
      end
      M_readdatavalid = 1'b0;
      #1;
      n_checks++;
      if (grant !== 3'b000) begin
         n_fail++;
         $display("FAIL wait_release: got grant=%b want 000", grant);
      end
   endtask

   task automatic test_short_write_run();
      int n = 0;
      @(negedge clk);
      W_write = 1'b1; W_address = 32'h0000_3000; W_writedata = 32'hDEAD_0000;
      B_read = 1'b1; B_address = 32'h0000_4000; B_burstcount = 8'd1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         W_writedata = 32'hDEAD_0000 + i;
         #1;
         n_checks++;
         if ({M_write, W_waitrequest, B_waitrequest, grant, M_writedata} !==
             {1'b1, 1'b0, 1'b1, 3'b010, 32'hDEAD_0000 + i}) begin
            n_fail++;
            $display("FAIL wr_accept_%0d: got wr=%b ww=%b bw=%b gnt=%b data=%h",
                     i, M_write, W_waitrequest, B_waitrequest, grant, M_writedata);
         end
         @(negedge clk);
      end
      W_write = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (grant !== 3'b000) begin
         n_fail++;
         $display("FAIL wr_exit_idle: got grant=%b want 000", grant);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({grant, M_read, M_address} !== {3'b100, 1'b1, 32'h0000_4000}) begin
         n_fail++;
         $display("FAIL wr_next_b: got gnt=%b rd=%b addr=%h want 100 1 00004000", grant, M_read, M_address);
      end
      @(negedge clk);
      B_read = 1'b0;
      M_readdatavalid = 1'b1; M_readdata = 32'h0000_0055;
      #1;
      n_checks++;
      if ({B_readdatavalid, A_readdatavalid, B_readdata} !== {1'b1, 1'b0, 32'h0000_0055}) begin
         n_fail++;
         $display("FAIL wr_b_beat: got brdv=%b ardv=%b data=%h want 1 0 00000055",
                  B_readdatavalid, A_readdatavalid, B_readdata);
      end
      @(negedge clk);
      M_readdatavalid = 1'b0;
      W_write = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (grant === 3'b010 && M_write === 1'b1) n++;
         if (grant === 3'b000 && n > 0) begin
            W_write = 1'b0;
            break;
         end
      end
      W_write = 1'b0;
      n_checks++;
      if (n != 16) begin
         n_fail++;
         $display("FAIL wr_run_cleared: got %0d writes want 16", n);
      end
   endtask

   task automatic test_burstcount_zero();
      @(negedge clk);
      B_read = 1'b1; B_address = 32'h0000_5000; B_burstcount = 8'd0;
      @(negedge clk);
      #1;
      n_checks++;
      if ({grant, M_read} !== 4'b100_1) begin
         n_fail++;
         $display("FAIL bc0_cmd: got gnt=%b rd=%b want 100 1", grant, M_read);
      end
      @(negedge clk);
      B_read = 1'b0;
      M_readdatavalid = 1'b1;
      #1;
      n_checks++;
      if ({grant, B_readdatavalid} !== 4'b100_1) begin
         n_fail++;
         $display("FAIL bc0_beat: got gnt=%b brdv=%b want 100 1", grant, B_readdatavalid);
      end
      @(negedge clk);
      M_readdatavalid = 1'b0;
      #1;
      n_checks++;
      if ({grant, protocol_error} !== 4'b000_0) begin
         n_fail++;
         $display("FAIL bc0_release: got gnt=%b err=%b want 000 0", grant, protocol_error);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [9:0] obs;
      int fwd = 0;
      @(negedge clk);
      B_read = 1'b1; B_address = 32'h0000_6000; B_burstcount = 8'd8;
      @(negedge clk);
      @(negedge clk);
      B_read = 1'b0;
      for (int i = 0; i < 2; i++) begin
         M_readdatavalid = 1'b1;
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      obs = {M_read, M_write, A_waitrequest, W_waitrequest, B_waitrequest,
             A_readdatavalid, B_readdatavalid, grant};
      n_checks++;
      if (obs !== 10'b00_111_00_000) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got %b want 0011100000", obs);
      end
      M_readdatavalid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (protocol_error !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_err_clear: got %b want 0", protocol_error);
      end
      for (int i = 0; i < 6; i++) begin
         M_readdatavalid = 1'b1;
         #1;
         if (B_readdatavalid !== 1'b0 || A_readdatavalid !== 1'b0) fwd++;
         @(negedge clk);
      end
      M_readdatavalid = 1'b0;
      #1;
      n_checks++;
      if (fwd != 0) begin
         n_fail++;
         $display("FAIL rst_mid_dropped: got %0d forwarded beats want 0", fwd);
      end
      n_checks++;
      if ({protocol_error, grant} !== 4'b1_000) begin
         n_fail++;
         $display("FAIL rst_mid_error: got err=%b gnt=%b want 1 000", protocol_error, grant);
      end
   endtask

   initial begin
      reset = 1'b1;
      A_read = 1'b0; A_address = '0; A_burstcount = '0;
      W_write = 1'b0; W_address = '0; W_writedata = '0;
      B_read = 1'b0; B_address = '0; B_burstcount = '0;
      M_waitrequest = 1'b0; M_readdatavalid = 1'b0; M_readdata = '0;
      test_reset();
      test_single_burst_a();
      test_round_robin();
      test_waitrequest();
      test_short_write_run();
      test_burstcount_zero();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
